// File: rtl/stage_if.sv
// Instruction-fetch stage: assembles a 32-bit little-endian instruction from four
// granted byte reads of the unified RAM and presents it to decode with a valid flag.
module stage_if #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_LATENCY = 1,
  parameter int          STALL_W     = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               branch_enable_i,
  input  logic [31:0]        branch_addr_i,
  input  logic               mem_grant_i,
  input  logic [7:0]         mem_din_i,
  output logic               mem_req_o,
  output logic [31:0]        mem_addr_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        inst_o,
  output logic               inst_valid_o,
  output logic               stallreq_o
);

  generate
    if (MEM_LATENCY != 1) begin : g_bad_latency
      $error("stage_if: only MEM_LATENCY = 1 is supported");
    end
  endgenerate

  typedef enum logic {
    S_FETCH = 1'b0,
    S_DONE  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [2:0]  r_issue_idx;
  logic [1:0]  r_cap_idx;
  logic        r_pending;
  logic [23:0] r_asm;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_pc_out;
  logic [31:0] r_inst;
  logic        r_valid;
  logic        r_stallreq;

  logic        w_granted;
  logic [2:0]  w_next_idx;
  logic        w_more;
  logic [31:0] w_next_addr;
  logic        w_unused_stall;

  // A byte is only issued when the request is actually on the bus and granted.
  assign w_granted      = r_mem_req & mem_grant_i;
  assign w_next_idx     = r_issue_idx + {2'b00, w_granted};
  assign w_more         = (w_next_idx < 3'd4);
  assign w_next_addr    = r_pc + {29'd0, w_next_idx};
  assign w_unused_stall = ^{stall_i[STALL_W-1:2], stall_i[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_issue_idx <= 3'd0;
      r_cap_idx   <= 2'd0;
      r_pending   <= 1'b0;
      r_asm       <= 24'd0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_pc_out    <= 32'd0;
      r_inst      <= 32'd0;
      r_valid     <= 1'b0;
      r_stallreq  <= 1'b0;
    end else if (rdy) begin
      if (branch_enable_i) begin
        // Redirect drops any in-flight byte and starts presenting the target at once.
        r_state     <= S_FETCH;
        r_pc        <= branch_addr_i;
        r_issue_idx <= 3'd0;
        r_pending   <= 1'b0;
        r_valid     <= 1'b0;
        r_mem_req   <= 1'b1;
        r_mem_addr  <= branch_addr_i;
        r_stallreq  <= 1'b1;
      end else begin
        case (r_state)
          S_FETCH: begin
            r_issue_idx <= w_next_idx;
            r_pending   <= w_granted;
            if (w_granted) begin
              r_cap_idx <= r_issue_idx[1:0];
            end
            r_mem_req  <= w_more;
            r_stallreq <= w_more;
            if (w_more) begin
              r_mem_addr <= w_next_addr;
            end
            if (r_pending) begin
              case (r_cap_idx)
                2'd0:    r_asm[7:0]   <= mem_din_i;
                2'd1:    r_asm[15:8]  <= mem_din_i;
                2'd2:    r_asm[23:16] <= mem_din_i;
                default: begin
                  r_inst   <= {mem_din_i, r_asm};
                  r_pc_out <= r_pc;
                  r_valid  <= 1'b1;
                  r_state  <= S_DONE;
                end
              endcase
            end
          end
          S_DONE: begin
            r_pending <= 1'b0;
            // Transfer to decode completes this cycle unless if_id is held.
            if (!stall_i[1]) begin
              r_pc        <= r_pc + 32'd4;
              r_valid     <= 1'b0;
              r_issue_idx <= 3'd0;
              r_state     <= S_FETCH;
              r_mem_req   <= 1'b1;
              r_mem_addr  <= r_pc + 32'd4;
              r_stallreq  <= 1'b1;
            end
          end
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

  assign mem_req_o    = r_mem_req;
  assign mem_addr_o   = r_mem_addr;
  assign pc_o         = r_pc_out;
  assign inst_o       = r_inst;
  assign inst_valid_o = r_valid;
  assign stallreq_o   = r_stallreq;

endmodule

// File: tb/tb_stage_if.sv
// Self-checking bench for stage_if: directed scenarios plus a randomized run
// checked against a transaction-level fetch model.
module tb_stage_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [5:0]  stall_i;
  logic        branch_enable_i;
  logic [31:0] branch_addr_i;
  logic        mem_grant_i;
  logic [7:0]  mem_din_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        stallreq_o;

  logic [7:0]  ram [0:1023];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  stage_if #(.RESET_PC(32'h0000_0000), .MEM_LATENCY(1), .STALL_W(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_i(stall_i),
    .branch_enable_i(branch_enable_i), .branch_addr_i(branch_addr_i),
    .mem_grant_i(mem_grant_i), .mem_din_i(mem_din_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .pc_o(pc_o), .inst_o(inst_o),
    .inst_valid_o(inst_valid_o), .stallreq_o(stallreq_o)
  );

  // RAM: one-cycle read latency, updates only for granted requests while the system runs.
  always @(posedge clk) begin
    if (rdy && mem_req_o && mem_grant_i) mem_din_i <= ram[mem_addr_o[9:0]];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] ramword(input logic [31:0] a);
    logic [31:0] a1, a2, a3;
    a1 = a + 32'd1; a2 = a + 32'd2; a3 = a + 32'd3;
    return {ram[a3[9:0]], ram[a2[9:0]], ram[a1[9:0]], ram[a[9:0]]};
  endfunction

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; branch_enable_i = 1'b0; branch_addr_i = 32'd0;
    stall_i = 6'd0; mem_grant_i = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b0; branch_enable_i = 1'b1; branch_addr_i = 32'h1234_5678;
    stall_i = 6'h3F; mem_grant_i = 1'b1;
    tick();
    checks++;
    if ({mem_req_o, mem_addr_o, pc_o, inst_o, inst_valid_o, stallreq_o} !== 99'd0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b addr=%h pc=%h inst=%h v=%b sr=%b want all 0",
               mem_req_o, mem_addr_o, pc_o, inst_o, inst_valid_o, stallreq_o);
    end
  endtask

  task automatic test_basic();
    ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'hA0; ram[3] = 8'h00;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({mem_req_o, mem_addr_o, stallreq_o} !== {1'b1, 32'(i), 1'b1}) begin
        errors++;
        $display("FAIL basic_issue t%0d got req=%b addr=%h sr=%b want req=1 addr=%h sr=1",
                 i, mem_req_o, mem_addr_o, stallreq_o, i);
      end
      tick();
    end
    checks++;
    if ({mem_req_o, inst_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL basic_t4 got req=%b valid=%b want 0 0", mem_req_o, inst_valid_o);
    end
    tick();
    checks++;
    if ({inst_valid_o, inst_o, pc_o, stallreq_o} !== {1'b1, 32'h00A0_0513, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL basic_present got v=%b inst=%h pc=%h sr=%b want 1 00a00513 0 0",
               inst_valid_o, inst_o, pc_o, stallreq_o);
    end
    tick();
    checks++;
    if ({mem_req_o, mem_addr_o, inst_valid_o} !== {1'b1, 32'd4, 1'b0}) begin
      errors++;
      $display("FAIL basic_next got req=%b addr=%h v=%b want 1 4 0", mem_req_o, mem_addr_o, inst_valid_o);
    end
  endtask

  task automatic test_grant_gaps();
    logic [31:0] exp_addr [6];
    logic        gnt [6];
    exp_addr = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd2, 32'd3};
    gnt      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({mem_req_o, mem_addr_o, inst_valid_o} !== {1'b1, exp_addr[c], 1'b0}) begin
        errors++;
        $display("FAIL gap_issue t%0d got req=%b addr=%h v=%b want 1 %h 0",
                 c, mem_req_o, mem_addr_o, inst_valid_o, exp_addr[c]);
      end
      mem_grant_i = gnt[c];
      tick();
    end
    mem_grant_i = 1'b1;
    checks++;
    if ({mem_req_o, inst_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL gap_t6 got req=%b v=%b want 0 0", mem_req_o, inst_valid_o);
    end
    tick();
    checks++;
    if ({inst_valid_o, inst_o, pc_o} !== {1'b1, 32'h00A0_0513, 32'd0}) begin
      errors++;
      $display("FAIL gap_present got v=%b inst=%h pc=%h want 1 00a00513 0", inst_valid_o, inst_o, pc_o);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({inst_valid_o, inst_o, pc_o, mem_req_o} !== {1'b1, 32'h00A0_0513, 32'd0, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold c%0d got v=%b inst=%h pc=%h req=%b want 1 00a00513 0 0",
                 c, inst_valid_o, inst_o, pc_o, mem_req_o);
      end
      stall_i = (c < 3) ? 6'b000010 : 6'b111101;
      tick();
    end
    stall_i = 6'd0;
    checks++;
    if ({mem_req_o, mem_addr_o, inst_valid_o} !== {1'b1, 32'd4, 1'b0}) begin
      errors++;
      $display("FAIL stall_release got req=%b addr=%h v=%b want 1 4 0", mem_req_o, mem_addr_o, inst_valid_o);
    end
  endtask

  task automatic test_branch();
    logic [31:0] want;
    do_reset();
    tick();
    tick();
    checks++;
    if (mem_addr_o !== 32'd2) begin
      errors++;
      $display("FAIL branch_pre got addr=%h want 2", mem_addr_o);
    end
    branch_enable_i = 1'b1; branch_addr_i = 32'h0000_0100;
    tick();
    branch_enable_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({mem_req_o, mem_addr_o, inst_valid_o} !== {1'b1, 32'h100 + 32'(i), 1'b0}) begin
        errors++;
        $display("FAIL branch_issue i%0d got req=%b addr=%h v=%b want 1 %h 0",
                 i, mem_req_o, mem_addr_o, inst_valid_o, 32'h100 + 32'(i));
      end
      tick();
    end
    tick();
    want = ramword(32'h100);
    checks++;
    if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 32'h100, want}) begin
      errors++;
      $display("FAIL branch_present got v=%b pc=%h inst=%h want 1 100 %h", inst_valid_o, pc_o, inst_o, want);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(); tick(); tick();
    checks++;
    if (mem_addr_o !== 32'd3) begin
      errors++;
      $display("FAIL rstmid_pre got addr=%h want 3", mem_addr_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({mem_req_o, mem_addr_o, pc_o, inst_o, inst_valid_o, stallreq_o} !== 99'd0) begin
      errors++;
      $display("FAIL rstmid_zero got req=%b addr=%h pc=%h inst=%h v=%b sr=%b want all 0",
               mem_req_o, mem_addr_o, pc_o, inst_o, inst_valid_o, stallreq_o);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({mem_req_o, mem_addr_o} !== {1'b1, 32'(i)}) begin
        errors++;
        $display("FAIL rstmid_issue i%0d got req=%b addr=%h want 1 %h", i, mem_req_o, mem_addr_o, i);
      end
      tick();
    end
    tick();
    checks++;
    if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 32'd0, 32'h00A0_0513}) begin
      errors++;
      $display("FAIL rstmid_present got v=%b pc=%h inst=%h want 1 0 00a00513", inst_valid_o, pc_o, inst_o);
    end
  endtask

  task automatic test_rdy_wrap();
    logic [31:0] want;
    do_reset();
    mem_grant_i = 1'b0;
    branch_enable_i = 1'b1; branch_addr_i = 32'hFFFF_FFFC;
    tick();
    branch_enable_i = 1'b0; mem_grant_i = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      logic [31:0] ea;
      ea = (c == 1) ? 32'hFFFF_FFFC : (c == 2) ? 32'hFFFF_FFFD :
           (c == 6) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
      checks++;
      if ({mem_req_o, mem_addr_o, inst_valid_o} !== {1'b1, ea, 1'b0}) begin
        errors++;
        $display("FAIL wrap_issue t%0d got req=%b addr=%h v=%b want 1 %h 0",
                 c, mem_req_o, mem_addr_o, inst_valid_o, ea);
      end
      rdy = (c == 3 || c == 4) ? 1'b0 : 1'b1;
      mem_grant_i = rdy;
      branch_enable_i = (c == 4);
      branch_addr_i = 32'h0000_0200;
      tick();
    end
    branch_enable_i = 1'b0;
    checks++;
    if ({mem_req_o, inst_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL wrap_t7 got req=%b v=%b want 0 0", mem_req_o, inst_valid_o);
    end
    tick();
    want = ramword(32'hFFFF_FFFC);
    checks++;
    if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 32'hFFFF_FFFC, want}) begin
      errors++;
      $display("FAIL wrap_present got v=%b pc=%h inst=%h want 1 fffffffc %h", inst_valid_o, pc_o, inst_o, want);
    end
    tick();
    checks++;
    if ({mem_req_o, mem_addr_o, inst_valid_o} !== {1'b1, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL wrap_next got req=%b addr=%h v=%b want 1 0 0", mem_req_o, mem_addr_o, inst_valid_o);
    end
  endtask

  // Transaction model: each instruction needs four granted byte requests at pc+k,
  // appears two cycles after the last grant, holds while if_id is stalled, then pc+4.
  task automatic test_random();
    logic [31:0] exp_pc, exp_inst;
    int          k, lat, ninstr;
    logic        fetching, pres;
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    exp_pc = $urandom;
    branch_enable_i = 1'b1; branch_addr_i = exp_pc; mem_grant_i = 1'b0; stall_i = 6'd0;
    tick();
    branch_enable_i = 1'b0;
    k = 0; lat = 0; ninstr = 0; fetching = 1'b1; exp_inst = 32'd0;
    for (int cyc = 0; cyc < 4000 && ninstr < 40; cyc++) begin
      pres = 1'b0;
      if (fetching && k < 4) begin
        checks++;
        if ({mem_req_o, mem_addr_o, inst_valid_o, stallreq_o} !== {1'b1, exp_pc + 32'(k), 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL rand_issue cyc%0d got req=%b addr=%h v=%b sr=%b want 1 %h 0 1",
                   cyc, mem_req_o, mem_addr_o, inst_valid_o, stallreq_o, exp_pc + 32'(k));
        end
      end else if (fetching) begin
        lat--;
        if (lat == 0) begin
          exp_inst = ramword(exp_pc);
          fetching = 1'b0;
          pres = 1'b1;
          checks++;
          if ({inst_valid_o, pc_o, inst_o} !== {1'b1, exp_pc, exp_inst}) begin
            errors++;
            $display("FAIL rand_present cyc%0d got v=%b pc=%h inst=%h want 1 %h %h",
                     cyc, inst_valid_o, pc_o, inst_o, exp_pc, exp_inst);
          end
        end else begin
          checks++;
          if ({mem_req_o, inst_valid_o} !== 2'b00) begin
            errors++;
            $display("FAIL rand_wait cyc%0d got req=%b v=%b want 0 0", cyc, mem_req_o, inst_valid_o);
          end
        end
      end else begin
        pres = 1'b1;
        checks++;
        if ({inst_valid_o, pc_o, inst_o, mem_req_o, stallreq_o} !== {1'b1, exp_pc, exp_inst, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL rand_hold cyc%0d got v=%b pc=%h inst=%h req=%b sr=%b want 1 %h %h 0 0",
                   cyc, inst_valid_o, pc_o, inst_o, mem_req_o, stallreq_o, exp_pc, exp_inst);
        end
      end
      mem_grant_i = ($urandom_range(0, 3) != 0);
      stall_i = 6'($urandom);
      if (!pres && fetching && k < 4 && mem_grant_i) begin
        k++;
        if (k == 4) lat = 2;
      end
      if (pres && !stall_i[1]) begin
        exp_pc = exp_pc + 32'd4;
        k = 0;
        fetching = 1'b1;
        ninstr++;
      end
      tick();
    end
    checks++;
    if (ninstr != 40) begin
      errors++;
      $display("FAIL rand_timeout got %0d instructions want 40", ninstr);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    mem_din_i = 8'd0;
    test_reset();
    test_basic();
    test_grant_gaps();
    test_stall();
    test_branch();
    test_reset_mid();
    test_rdy_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
